rr_arb_param: RTL and testbench

// - N-requester round-robin arbiter with registered one-hot grant and per-owner hold limit.
// - Generalises the fixed 2-requester arbiter.
// - Sits between bus masters and a shared resource.
// - One grant at a time, starvation-free; grant persists while the owner keeps requesting.

---
 rtl/rr_arb_param.sv | 125 ++++++++++++
 tb/tb_rr_arb_param.sv | 122 ++++++++++++
 2 files changed

// File: rtl/rr_arb_param.sv
// rtl/rr_arb_param.sv - N-requester round-robin arbiter with registered one-hot grant and hold limit
// Optional feature macro: ARB_LOCK_EN (adds lock input that freezes the hold counter)
module rr_arb_param #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   request,
`ifdef ARB_LOCK_EN
  input  logic           lock,
`endif
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id
);

  // A zero-width counter is illegal, so MAX_HOLD==0 still gets one (unused) bit.
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] ptr;
  logic [HW-1:0]  hold_cnt;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW:0]   scan_sum;
  logic [IDW-1:0] scan_idx;

  logic           owner_req;
  logic           others_req;
  logic           lock_active;
  logic           take_new;
  logic           go_idle;
  logic [HW-1:0]  hold_nxt;

`ifdef ARB_LOCK_EN
  assign lock_active = lock;
`else
  assign lock_active = 1'b0;
`endif

  // Cyclic search starting at ptr; wrap by explicit compare so any N is legal.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < N; k++) begin
      scan_sum = {1'b0, ptr} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(N)) begin
        scan_sum = scan_sum - (IDW+1)'(N);
      end
      scan_idx = scan_sum[IDW-1:0];
      if (!win_found && request[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
    ptr_nxt = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
  end

  // Decide between taking a new winner, releasing to idle, or keeping the owner.
  always_comb begin
    owner_req  = |(request & grant);
    others_req = |(request & ~grant);
    take_new   = 1'b0;
    go_idle    = 1'b0;
    hold_nxt   = hold_cnt;
    if (state == IDLE) begin
      take_new = win_found;
    end else if (!owner_req) begin
      if (others_req) begin
        take_new = 1'b1;
      end else begin
        go_idle = 1'b1;
      end
    end else if (MAX_HOLD == 0) begin
      hold_nxt = '0;
    end else if (lock_active) begin
      hold_nxt = hold_cnt;
    end else if (!others_req) begin
      hold_nxt = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
    end else if (hold_cnt == HOLD_LAST) begin
      take_new = 1'b1;
    end else begin
      hold_nxt = hold_cnt + 1'b1;
    end
  end

  // Registered grant, pointer and hold counter; reset overrides any grant in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else if (take_new) begin
      state       <= BUSY;
      grant       <= {{(N-1){1'b0}}, 1'b1} << win_idx;
      grant_valid <= 1'b1;
      grant_id    <= win_idx;
      ptr         <= ptr_nxt;
      hold_cnt    <= '0;
    end else if (go_idle) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      hold_cnt    <= '0;
    end else begin
      hold_cnt    <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arb_param.sv
// tb/tb_rr_arb_param.sv - scoreboard bench for rr_arb_param with directed vectors
module tb_rr_arb_param;

  logic       clk;
  logic       reset;
  logic [3:0] request;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
`ifdef ARB_LOCK_EN
  logic       lock;
`endif

  typedef struct {
    logic [3:0] g;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks;
  int   errors;

  rr_arb_param #(.N(4), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .request     (request),
`ifdef ARB_LOCK_EN
    .lock        (lock),
`endif
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] id_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Drive inputs for the next edge and record the grant expected right after it.
  task automatic step(input logic rst_n, input logic [3:0] req, input logic [3:0] exp_g, input string name);
    exp_t x;
    @(negedge clk);
    reset   = rst_n;
    request = req;
    x.g     = exp_g;
    x.name  = name;
    q.push_back(x);
  endtask

  task automatic steps(input int n, input logic [3:0] req, input logic [3:0] exp_g, input string name);
    for (int i = 0; i < n; i++) step(1'b1, req, exp_g, name);
  endtask

  // Monitor: after each edge, pop one expectation and compare all outputs.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (grant !== e.g || grant_valid !== (|e.g) || grant_id !== id_of(e.g)) begin
        errors++;
        $display("FAIL %s: got grant=%b valid=%b id=%0d, expected grant=%b valid=%b id=%0d",
                 e.name, grant, grant_valid, grant_id, e.g, |e.g, id_of(e.g));
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    request = 4'b0000;
`ifdef ARB_LOCK_EN
    lock    = 1'b0;
`endif

    step(1'b0, 4'b1111, 4'b0000, "reset0");
    step(1'b0, 4'b1111, 4'b0000, "reset1");

    steps(3, 4'b0100, 4'b0100, "single_req");
    step(1'b1, 4'b0000, 4'b0000, "single_drop");

    steps(4, 4'b0011, 4'b0001, "hold_r0_first");
    steps(4, 4'b0011, 4'b0010, "hold_r1");
    steps(1, 4'b0011, 4'b0001, "hold_r0_again");

    step(1'b1, 4'b0000, 4'b0000, "idle_gap");
    steps(2, 4'b1000, 4'b1000, "owner3");
    step(1'b1, 4'b0101, 4'b0001, "wrap_no_bubble");
    step(1'b1, 4'b0101, 4'b0001, "wrap_hold");

    step(1'b1, 4'b1000, 4'b1000, "handoff_to3");
    step(1'b0, 4'b1000, 4'b0000, "midop_reset");
    steps(2, 4'b1001, 4'b0001, "after_reset_ptr0");

    step(1'b1, 4'b0000, 4'b0000, "idle_again");
    steps(4, 4'b1101, 4'b0100, "three_way_r2");
    steps(4, 4'b1101, 4'b1000, "three_way_r3");
    steps(1, 4'b1101, 4'b0001, "three_way_r0");

    repeat (2) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
